// File: rtl/evr_stream_decoder.sv
// Event-receiver stream decoder: comma alignment, event/distributed-bus decode and heartbeat.
// Time-of-day seconds decoding is built only when EVR_TOD_DECODE_EN is defined.
module evr_stream_decoder #(
  parameter int RXCLK_NOMINAL_FREQUENCY = 125000000,
  parameter int TOD_SECONDS_WIDTH       = 32,
  parameter int HEARTBEAT_TIMEOUT       = 200000000,
  parameter int COMMA_MAX_GAP           = 8,
  parameter int ALIGN_COMMAS            = 4
) (
  input  logic                         evrRxClk,
  input  logic                         evrRxResetN,
  input  logic [15:0]                  evrRxData,
  input  logic [1:0]                   evrRxCharIsK,
  input  logic                         evrRxValid,
  output logic [7:0]                   evrEventTDATA,
  output logic                         evrEventTVALID,
  output logic [7:0]                   evrDistributedBus,
  output logic                         evrPPStoggle,
  output logic [TOD_SECONDS_WIDTH-1:0] evrSeconds,
  output logic                         evrSecondsValid,
  output logic [7:0]                   evrTodErrors,
  output logic                         evrHeartbeatLost,
  output logic                         evrLinkAligned,
  output logic [1:0]                   dbg_state_o
);

  localparam int HB_W  = (HEARTBEAT_TIMEOUT > 2) ? $clog2(HEARTBEAT_TIMEOUT) : 1;
  localparam int GAP_W = (COMMA_MAX_GAP > 0) ? $clog2(COMMA_MAX_GAP + 1) : 1;
  localparam int CNT_W = $clog2(ALIGN_COMMAS + 1);
  localparam logic [HB_W-1:0]  HB_RELOAD = HB_W'(HEARTBEAT_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_MAX   = GAP_W'(COMMA_MAX_GAP);

  if (TOD_SECONDS_WIDTH < 2 || HEARTBEAT_TIMEOUT < 1 || ALIGN_COMMAS < 1 ||
      COMMA_MAX_GAP < 1 || RXCLK_NOMINAL_FREQUENCY < 1) begin : g_bad_params
    $error("evr_stream_decoder: illegal parameter value");
  end

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_ALIGNED = 2'd2
  } state_e;

  // Reset asserts asynchronously but releases only on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge evrRxClk or negedge evrRxResetN) begin
    if (!evrRxResetN) rst_sync_q <= 2'b00;
    else              rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] comma_cnt_q, comma_cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [HB_W-1:0]  hb_cnt_q, hb_cnt_d;
  logic             hb_lost_q, hb_lost_d;
  logic [7:0]       evt_data_q;
  logic             evt_valid_q;
  logic [7:0]       bus_q;

  logic       comma_ok, illegal, gap_ovf, abort, take, evt_hit, hb_hit;
  logic [7:0] code;

  assign code     = evrRxData[7:0];
  assign comma_ok = evrRxValid && (evrRxCharIsK == 2'b01) && (code == 8'hBC);
  assign illegal  = (evrRxCharIsK != 2'b00) && !((evrRxCharIsK == 2'b01) && (code == 8'hBC));
  assign gap_ovf  = !comma_ok && (gap_q >= GAP_MAX);
  assign abort    = !evrRxValid || illegal || gap_ovf;
  // A word is trusted only while aligned and not itself breaking alignment.
  assign take     = (state_q == ST_ALIGNED) && !abort;
  assign evt_hit  = take && !evrRxCharIsK[0] && (code != 8'h00);
  assign hb_hit   = evt_hit && (code == 8'h7A);

  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    gap_d       = gap_q;
    if (comma_ok)             gap_d = '0;
    else if (gap_q != GAP_MAX) gap_d = gap_q + GAP_W'(1);
    case (state_q)
      ST_HUNT: begin
        if (comma_ok) begin
          state_d     = (ALIGN_COMMAS <= 1) ? ST_ALIGNED : ST_SYNC;
          comma_cnt_d = CNT_W'(1);
        end
      end
      ST_SYNC: begin
        if (abort) begin
          state_d     = ST_HUNT;
          comma_cnt_d = '0;
        end else if (comma_ok) begin
          comma_cnt_d = comma_cnt_q + CNT_W'(1);
          if (comma_cnt_q == CNT_W'(ALIGN_COMMAS - 1)) state_d = ST_ALIGNED;
        end
      end
      ST_ALIGNED: begin
        if (abort) begin
          state_d     = ST_HUNT;
          comma_cnt_d = '0;
        end
      end
      default: begin
        state_d     = ST_HUNT;
        comma_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    hb_cnt_d  = hb_cnt_q;
    hb_lost_d = hb_lost_q;
    if (hb_hit) begin
      hb_cnt_d  = HB_RELOAD;
      hb_lost_d = 1'b0;
    end else if (hb_cnt_q == '0) begin
      hb_lost_d = 1'b1;
    end else begin
      hb_cnt_d = hb_cnt_q - HB_W'(1);
      if (hb_cnt_q == HB_W'(1)) hb_lost_d = 1'b1;
    end
  end

  always_ff @(posedge evrRxClk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HUNT;
      comma_cnt_q <= '0;
      gap_q       <= '0;
      hb_cnt_q    <= HB_RELOAD;
      hb_lost_q   <= 1'b0;
      evt_data_q  <= 8'h00;
      evt_valid_q <= 1'b0;
      bus_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
      gap_q       <= gap_d;
      hb_cnt_q    <= hb_cnt_d;
      hb_lost_q   <= hb_lost_d;
      evt_valid_q <= evt_hit;
      if (evt_hit) evt_data_q <= code;
      if (take && !evrRxCharIsK[1]) bus_q <= evrRxData[15:8];
    end
  end

`ifdef EVR_TOD_DECODE_EN
  localparam int BIT_W = $clog2(TOD_SECONDS_WIDTH + 2);
  localparam logic [BIT_W-1:0] BIT_FULL = BIT_W'(TOD_SECONDS_WIDTH);
  localparam logic [BIT_W-1:0] BIT_SAT  = BIT_W'(TOD_SECONDS_WIDTH + 1);

  logic [TOD_SECONDS_WIDTH-1:0] tod_shift_q, tod_shift_d;
  logic [TOD_SECONDS_WIDTH-1:0] seconds_q, seconds_d;
  logic [BIT_W-1:0]             bit_cnt_q, bit_cnt_d;
  logic                         sec_valid_q, sec_valid_d;
  logic [7:0]                   tod_err_q, tod_err_d;

  always_comb begin
    tod_shift_d = tod_shift_q;
    seconds_d   = seconds_q;
    bit_cnt_d   = bit_cnt_q;
    sec_valid_d = sec_valid_q;
    tod_err_d   = tod_err_q;
    if (state_q != ST_ALIGNED) begin
      bit_cnt_d = '0;
    end else if (evt_hit) begin
      if (code == 8'h70 || code == 8'h71) begin
        tod_shift_d = {tod_shift_q[TOD_SECONDS_WIDTH-2:0], code[0]};
        if (bit_cnt_q != BIT_SAT) bit_cnt_d = bit_cnt_q + BIT_W'(1);
      end else if (code == 8'h7D) begin
        bit_cnt_d = '0;
        if (bit_cnt_q == BIT_FULL) begin
          seconds_d   = tod_shift_q;
          sec_valid_d = 1'b1;
        end else begin
          sec_valid_d = 1'b0;
          if (tod_err_q != 8'hFF) tod_err_d = tod_err_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge evrRxClk or negedge rst_n) begin
    if (!rst_n) begin
      tod_shift_q <= '0;
      seconds_q   <= '0;
      bit_cnt_q   <= '0;
      sec_valid_q <= 1'b0;
      tod_err_q   <= 8'h00;
    end else begin
      tod_shift_q <= tod_shift_d;
      seconds_q   <= seconds_d;
      bit_cnt_q   <= bit_cnt_d;
      sec_valid_q <= sec_valid_d;
      tod_err_q   <= tod_err_d;
    end
  end

  assign evrSeconds      = seconds_q;
  assign evrSecondsValid = sec_valid_q;
  assign evrTodErrors    = tod_err_q;
`else
  assign evrSeconds      = '0;
  assign evrSecondsValid = 1'b0;
  assign evrTodErrors    = 8'h00;
`endif

  assign evrEventTDATA     = evt_data_q;
  assign evrEventTVALID    = evt_valid_q;
  assign evrDistributedBus = bus_q;
  assign evrPPStoggle      = bus_q[3];
  assign evrHeartbeatLost  = hb_lost_q;
  assign evrLinkAligned    = (state_q == ST_ALIGNED);
  assign dbg_state_o       = state_q;

endmodule
